wb_gpio_irq: RTL and testbench
==============================

// Module: wb_gpio_irq
// PURPOSE
//  Parametrised Wishbone GPIO peripheral for the picorv32 SoC; supersedes the fixed LED-only block.
//  Per-pin output data and direction, synchronised input sampling, and per-pin edge interrupts with W1C status.
//  Sits as a Wishbone classic slave on the system intercon; irq_o feeds one bit of the CPU irq vector.
//  Pad tristates live at top level: pad = gpio_oe_o[i] ? gpio_o[i] : 1'bz; gpio_i = pad.
// PARAMETERS
//  GPIO_WIDTH   32  number of pins, 1..32; register bits >= GPIO_WIDTH read 0, writes ignored
//  SYNC_STAGES  2   input synchroniser flops per pin, 2..4
// PORTS
//  clk_i       in   1           system clock
//  rst_n_i     in   1           asynchronous, active-low reset
//  wb_cyc_i    in   1           Wishbone cycle
//  wb_stb_i    in   1           Wishbone strobe
//  wb_we_i     in   1           1 = write
//  wb_adr_i    in   32          byte address; only [4:2] decoded
//  wb_sel_i    in   4           byte lane enables for writes
//  wb_dat_i    in   32          write data
//  wb_dat_o    out  32          read data, valid while wb_ack_o = 1
//  wb_ack_o    out  1           transfer acknowledge
//  gpio_i      in   GPIO_WIDTH  asynchronous pad inputs
//  gpio_o      out  GPIO_WIDTH  output data
//  gpio_oe_o   out  GPIO_WIDTH  output enable per pin, 1 = drive
//  irq_o       out  1           level interrupt, registered
// BEHAVIOUR
//  Reset (async assert, sync release): wb_ack_o=0, wb_dat_o=0, gpio_o=0, gpio_oe_o=0, irq_o=0, all regs/sync/prev flops 0.
//  Register map (adr[4:2]): 0 OUT rw | 1 IN ro | 2 DIR rw (1=output) | 3 IRQ_EN rw | 4 IRQ_MODE rw (1=rise,0=fall)
//   | 5 IRQ_STAT rw1c | 6 OUT_SET wo | 7 OUT_CLR wo (6/7 only with macro, see CONFIGURATION).
//  Handshake: ack registered; cycle N sees cyc&stb&!ack -> ack=1 in cycle N+1 for exactly one cycle, then 0.
//   Back-to-back: master holding stb gets ack every second cycle. Write side-effects take effect at the ack edge.
//  Writes honour wb_sel_i per byte; unmapped or RO address: write dropped, read returns 0, still acked (no err/stall).
//  gpio_o = OUT, gpio_oe_o = DIR, driven straight from registers (write visible cycle after ack edge).
//  IN = last stage of SYNC_STAGES synchroniser; pad change visible in IN after SYNC_STAGES clk edges.
//  Edge detect: prev <= sync; rise = sync&~prev, fall = ~sync&prev; evt = IRQ_EN & (IRQ_MODE ? rise : fall).
//   IRQ_STAT[i] set on evt[i]; cleared by writing 1 to IRQ_STAT[i]; set wins over simultaneous clear.
//   Clearing IRQ_EN does not clear IRQ_STAT; status only accumulates while enabled.
//  irq_o <= |(IRQ_STAT & IRQ_EN); pad edge -> irq_o high SYNC_STAGES+2 cycles later.
//  Reading IN is unaffected by DIR (output pins read back their pad value).
//  Reset mid-transfer: ack and pending write abandoned; master must reissue.
// CONFIGURATION
//  WB_GPIO_ATOMIC_EN defined: adr 6 OUT_SET (OUT |= data), adr 7 OUT_CLR (OUT &= ~data), sel-masked, read 0;
//   both apply to OUT in the same edge as the ack; a single access never touches other bits.
//  Undefined: adr 6/7 behave as unmapped (write dropped, read 0, acked).
// TESTING
//  Reset: assert rst_n_i mid-write -> all outputs 0, no ack on release; OUT/DIR read 0.
//  Write OUT=0xA5A5_5A5A sel=4'b0011, DIR=0xFFFF_FFFF -> OUT reads 0x0000_5A5A, gpio_oe_o all 1, ack 1-cycle pulse.
//  GPIO_WIDTH=8: write OUT=0xFFFF_FFFF -> reads 0x0000_00FF; read adr 0x1C without macro -> 0.
//  gpio_i[3] 0->1, IRQ_EN=0x8, IRQ_MODE=0x8 -> IN[3]=1 after 2 cycles, IRQ_STAT=0x8, irq_o=1 after 4; fall edge ignored.
//  W1C IRQ_STAT=0x8 same cycle as new rise on pin 3 -> IRQ_STAT stays 0x8, irq_o stays 1; clean W1C -> irq_o 0 next cycle.
//  WB_GPIO_ATOMIC_EN: OUT=0x0F, OUT_SET 0xF0 -> 0xFF, OUT_CLR 0x3C -> 0xC3; without macro OUT stays 0x0F.

Source files
------------

// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO with synchronised inputs and per-pin edge IRQs.
// Define WB_GPIO_ATOMIC_EN to add OUT_SET (adr 6) and OUT_CLR (adr 7).
module wb_gpio_irq #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam int W = GPIO_WIDTH;

  logic [W-1:0] out_q, out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] en_q, en_d;
  logic [W-1:0] mode_q, mode_d;
  logic [W-1:0] stat_q, stat_d;
  logic [W-1:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic         ack_q, ack_d;
  logic         irq_q, irq_d;
  logic [31:0]  dat_q, dat_d;

  logic         req, wr;
  logic [2:0]   adr;
  logic [31:0]  m;
  logic [W-1:0] wd, wm, in_w;
  logic [W-1:0] rise, fall, evt, clr;
  logic [31:0]  rdata;
  logic         unused;

  assign req  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr   = req & wb_we_i;
  assign adr  = wb_adr_i[4:2];
  assign m    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                 {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wd   = wb_dat_i[W-1:0] & m[W-1:0];
  assign wm   = m[W-1:0];
  assign in_w = sync_q[SYNC_STAGES-1];

  assign unused = ^{wb_adr_i[31:5], wb_adr_i[1:0],
                    wb_dat_i, m};

  assign rise = in_w & ~prev_q;
  assign fall = ~in_w & prev_q;
  assign evt  = en_q & ((mode_q & rise) | (~mode_q & fall));

  // Synchroniser shift chain and previous-sample capture
  always_comb begin
    sync_d[0] = gpio_i;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
    prev_d = in_w;
  end

  // Read mux; unmapped and write-only addresses return 0
  always_comb begin
    rdata = '0;
    case (adr)
      3'd0: rdata = 32'(out_q);
      3'd1: rdata = 32'(in_w);
      3'd2: rdata = 32'(dir_q);
      3'd3: rdata = 32'(en_q);
      3'd4: rdata = 32'(mode_q);
      3'd5: rdata = 32'(stat_q);
      default: rdata = '0;
    endcase
  end

  // Register writes, W1C status with set priority, bus response
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr) begin
      case (adr)
        3'd0: out_d  = (out_q & ~wm) | wd;
        3'd2: dir_d  = (dir_q & ~wm) | wd;
        3'd3: en_d   = (en_q & ~wm) | wd;
        3'd4: mode_d = (mode_q & ~wm) | wd;
        3'd5: clr    = wd;
`ifdef WB_GPIO_ATOMIC_EN
        3'd6: out_d  = out_q | wd;
        3'd7: out_d  = out_q & ~wd;
`endif
        default: ;
      endcase
    end
    stat_d = (stat_q & ~clr) | evt;
    irq_d  = |(stat_q & en_q);
    ack_d  = req;
    dat_d  = (req & ~wb_we_i) ? rdata : '0;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      mode_q <= '0;
      stat_q <= '0;
      prev_q <= '0;
      sync_q <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      stat_q <= stat_d;
      prev_q <= prev_d;
      sync_q <= sync_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
      dat_q  <= dat_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq: 32-pin and 8-pin instances
// share one bus; expected values are hand-computed constants.
module tb_wb_gpio_irq;

`ifdef WB_GPIO_ATOMIC_EN
  localparam bit ATOM = 1'b1;
`else
  localparam bit ATOM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] gpio_i;

  logic [31:0] dat32, go32, oe32;
  logic        ack32, irq32;
  logic [31:0] dat8;
  logic [7:0]  go8, oe8;
  logic        ack8, irq8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_gpio_irq #(.GPIO_WIDTH(32), .SYNC_STAGES(2)) u32 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(dat32), .wb_ack_o(ack32),
    .gpio_i(gpio_i), .gpio_o(go32), .gpio_oe_o(oe32),
    .irq_o(irq32)
  );

  wb_gpio_irq #(.GPIO_WIDTH(8), .SYNC_STAGES(2)) u8 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(dat8), .wb_ack_o(ack8),
    .gpio_i(gpio_i[7:0]), .gpio_o(go8), .gpio_oe_o(oe8),
    .irq_o(irq8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic xfer(input logic w,
                      input logic [31:0] a,
                      input logic [3:0] s,
                      input logic [31:0] d,
                      output logic [31:0] r32,
                      output logic [31:0] r8);
    bit got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; sel = s; wdat = d;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk); #1;
      if (ack32) got = 1'b1;
    end
    r32 = dat32;
    r8  = dat8;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] x, y;
    xfer(1'b1, a, s, d, x, y);
  endtask

  logic [31:0] r32, r8;
  int nack;

  initial begin
    rst_n = 1'b1;
    cyc = 0; stb = 0; we = 0;
    adr = 0; sel = 0; wdat = 0;
    gpio_i = 0;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_ack", 32'(ack32), 0);
    chk("rst_dat", dat32, 0);
    chk("rst_gpio_o", go32, 0);
    chk("rst_oe", oe32, 0);
    chk("rst_irq", 32'(irq32), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // byte-lane write to OUT, then full DIR
    wr(32'h0, 32'hA5A5_5A5A, 4'b0011);
    chk("gpio_o_sel", go32, 32'h0000_5A5A);
    @(posedge clk); #1;
    chk("ack_pulse", 32'(ack32), 0);
    xfer(0, 32'h0, 4'hF, 0, r32, r8);
    chk("out_sel_rd", r32, 32'h0000_5A5A);
    wr(32'h8, 32'hFFFF_FFFF, 4'hF);
    chk("oe32", oe32, 32'hFFFF_FFFF);
    chk("oe8", 32'(oe8), 32'hFF);

    // back-to-back: held strobe acks every second cycle
    cyc = 1; stb = 1; we = 0; adr = 0; sel = 4'hF;
    nack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      nack += int'(ack32);
    end
    cyc = 0; stb = 0;
    chk("b2b_acks", nack, 2);
    @(posedge clk); #1;

    // width truncation and unmapped read
    wr(32'h0, 32'hFFFF_FFFF, 4'hF);
    xfer(0, 32'h0, 4'hF, 0, r32, r8);
    chk("out32_full", r32, 32'hFFFF_FFFF);
    chk("out8_trunc", r8, 32'h0000_00FF);
    xfer(0, 32'h1C, 4'hF, 0, r32, r8);
    chk("rd_1c", r32, 0);

    // atomic set/clear
    wr(32'h0, 32'h0F, 4'hF);
    wr(32'h18, 32'hF0, 4'hF);
    xfer(0, 32'h0, 4'hF, 0, r32, r8);
    chk("out_set", r32, ATOM ? 32'hFF : 32'h0F);
    wr(32'h1C, 32'h3C, 4'hF);
    xfer(0, 32'h0, 4'hF, 0, r32, r8);
    chk("out_clr", r32, ATOM ? 32'hC3 : 32'h0F);
    xfer(0, 32'h18, 4'hF, 0, r32, r8);
    chk("rd_18", r32, 0);

    // rising-edge interrupt on pin 3
    wr(32'hC, 32'h8, 4'hF);
    wr(32'h10, 32'h8, 4'hF);
    gpio_i = 32'h8;
    repeat (3) begin @(posedge clk); #1; end
    chk("irq_early", 32'(irq32), 0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq32), 1);
    xfer(0, 32'h4, 4'hF, 0, r32, r8);
    chk("in_rd", r32, 32'h8);
    xfer(0, 32'h14, 4'hF, 0, r32, r8);
    chk("stat_rise", r32, 32'h8);

    // clean W1C drops irq one cycle later
    wr(32'h14, 32'h8, 4'hF);
    chk("irq_hold", 32'(irq32), 1);
    @(posedge clk); #1;
    chk("irq_clr", 32'(irq32), 0);

    // falling edge ignored in rise mode
    gpio_i = 32'h0;
    repeat (6) begin @(posedge clk); #1; end
    chk("irq_fall", 32'(irq32), 0);
    xfer(0, 32'h14, 4'hF, 0, r32, r8);
    chk("stat_fall", r32, 0);

    // set wins over simultaneous W1C
    gpio_i = 32'h8;
    repeat (6) begin @(posedge clk); #1; end
    gpio_i = 32'h0;
    repeat (6) begin @(posedge clk); #1; end
    chk("irq_pre", 32'(irq32), 1);
    gpio_i = 32'h8;
    repeat (2) begin @(posedge clk); #1; end
    wr(32'h14, 32'h8, 4'hF);
    @(posedge clk); #1;
    chk("irq_race", 32'(irq32), 1);
    xfer(0, 32'h14, 4'hF, 0, r32, r8);
    chk("stat_race", r32, 32'h8);

    // disabling IRQ_EN keeps status, masks irq
    wr(32'hC, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("irq_masked", 32'(irq32), 0);
    xfer(0, 32'h14, 4'hF, 0, r32, r8);
    chk("stat_kept", r32, 32'h8);

    // reset in the middle of a write
    cyc = 1; stb = 1; we = 1;
    adr = 0; sel = 4'hF; wdat = 32'hFFFF_FFFF;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", oe32, 0);
    chk("mid_rst_out", go32, 0);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ack", 32'(ack32), 0);
    xfer(0, 32'h0, 4'hF, 0, r32, r8);
    chk("mid_rst_out_rd", r32, 0);
    xfer(0, 32'h8, 4'hF, 0, r32, r8);
    chk("mid_rst_dir_rd", r32, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
